// File: rtl/peri_bus_pkg.sv
// Shared types and helpers for the peripheral bus bridge.
// Window index decode lives here so address maps agree across the slice.
package peri_bus_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} peri_state_e;

    localparam int IDX_W = 4;

    function automatic logic [IDX_W-1:0] decode_idx(input logic [31:0] addr, input int win_lsb);
        logic [31:0] shifted;
        shifted = addr >> win_lsb;
        return shifted[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/peri_bus_bridge.sv
// Single-outstanding bridge from the core peripheral port to NSlaves 4 KiB windows.
// Unmapped or hung accesses are terminated locally with a zero response and a sticky error.
module peri_bus_bridge
    import peri_bus_pkg::*;
#(
    parameter int NSlaves       = 4,
    parameter int WinLsb        = 12,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    peri_req,
    input  logic [31:0]             peri_addr,
    input  logic                    peri_write,
    input  logic [3:0]              peri_be,
    input  logic [31:0]             peri_wdata,
    output logic                    peri_gnt,
    output logic                    peri_rvalid,
    output logic [31:0]             peri_rdata,
    output logic [NSlaves-1:0]      slv_req,
    output logic [31:0]             slv_addr,
    output logic                    slv_we,
    output logic [3:0]              slv_be,
    output logic [31:0]             slv_wdata,
    input  logic [NSlaves-1:0]      slv_gnt,
    input  logic [NSlaves-1:0]      slv_rvalid,
    input  logic [32*NSlaves-1:0]   slv_rdata,
    output logic                    bus_err
);

    localparam int              CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [31:0]     WinMask = (32'h1 << WinLsb) - 32'h1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    peri_state_e      r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [CntW-1:0]  r_cnt;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic             r_busErr;

    logic [IDX_W-1:0]   w_idx;
    logic               w_decodeOk;
    logic               w_inReq;
    logic               w_timeout;
    logic               w_selGnt;
    logic               w_selRvalid;
    logic [31:0]        w_selRdata;
    logic [NSlaves-1:0] w_slvReq;

    assign w_idx      = decode_idx(peri_addr, WinLsb);
    assign w_decodeOk = (int'(w_idx) < NSlaves) && ((peri_addr >> (WinLsb + IDX_W)) == 32'h0);
    assign w_inReq    = (r_state == REQ);
    assign w_timeout  = (r_cnt == CntLast);

    // Held off while the previous response is still on the port, so grants resume the cycle after.
    assign peri_gnt = (r_state == IDLE) && !r_rvalid && peri_req;

    always_comb begin
        w_selGnt    = 1'b0;
        w_selRvalid = 1'b0;
        w_selRdata  = '0;
        w_slvReq    = '0;
        for (int i = 0; i < NSlaves; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_selGnt    = slv_gnt[i];
                w_selRvalid = slv_rvalid[i];
                w_selRdata  = slv_rdata[32*i +: 32];
                w_slvReq[i] = w_inReq;
            end
        end
    end

    assign slv_req     = w_slvReq;
    assign slv_addr    = w_inReq ? r_addr  : '0;
    assign slv_we      = w_inReq ? r_we    : 1'b0;
    assign slv_be      = w_inReq ? r_be    : '0;
    assign slv_wdata   = w_inReq ? r_wdata : '0;
    assign peri_rvalid = r_rvalid;
    assign peri_rdata  = r_rdata;
    assign bus_err     = r_busErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_busErr <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            case (r_state)
                IDLE: begin
                    if (peri_gnt) begin
                        r_idx   <= w_idx;
                        r_addr  <= peri_addr & WinMask;
                        r_we    <= peri_write;
                        r_be    <= peri_be;
                        r_wdata <= peri_wdata;
                        r_cnt   <= '0;
                        if (w_decodeOk) begin
                            r_state <= REQ;
                        end else begin
                            r_state  <= ERR;
                            r_rvalid <= 1'b1;
                            r_busErr <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A grant on the final counted cycle still wins over the timeout.
                    if (w_selGnt) begin
                        r_cnt <= '0;
                        if (w_selRvalid) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_we ? 32'h0 : w_selRdata;
                            r_state  <= IDLE;
                        end else begin
                            r_state <= RESP;
                        end
                    end else if (w_timeout) begin
                        r_rvalid <= 1'b1;
                        r_busErr <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                RESP: begin
                    if (w_selRvalid) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_we ? 32'h0 : w_selRdata;
                        r_state  <= IDLE;
                    end else if (w_timeout) begin
                        r_rvalid <= 1'b1;
                        r_busErr <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peri_bus_bridge.sv
// Self-checking bench for peri_bus_bridge: directed vector table, hand-written reset
// sequence, and randomized accesses checked against a cycle-count reference model.
module tb_peri_bus_bridge;

   localparam int NS = 4;
   localparam int T  = 20;

   logic              clk;
   logic              rst_n;
   logic              peri_req;
   logic [31:0]       peri_addr;
   logic              peri_write;
   logic [3:0]        peri_be;
   logic [31:0]       peri_wdata;
   logic              peri_gnt;
   logic              peri_rvalid;
   logic [31:0]       peri_rdata;
   logic [NS-1:0]     slv_req;
   logic [31:0]       slv_addr;
   logic              slv_we;
   logic [3:0]        slv_be;
   logic [31:0]       slv_wdata;
   logic [NS-1:0]     slv_gnt;
   logic [NS-1:0]     slv_rvalid;
   logic [32*NS-1:0]  slv_rdata;
   logic              bus_err;

   int nChecks;
   int nFails;
   logic expBusErr;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          g;
      int          r;
      logic [31:0] sdata;
      bit          spur;
      int          expLat;
      logic [31:0] expRd;
      bit          expErr;
      int          expReq;
   } vec_t;

   vec_t vecs[10];

   peri_bus_bridge #(
      .NSlaves(NS),
      .WinLsb(12),
      .TimeoutCycles(T)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .peri_req(peri_req),
      .peri_addr(peri_addr),
      .peri_write(peri_write),
      .peri_be(peri_be),
      .peri_wdata(peri_wdata),
      .peri_gnt(peri_gnt),
      .peri_rvalid(peri_rvalid),
      .peri_rdata(peri_rdata),
      .slv_req(slv_req),
      .slv_addr(slv_addr),
      .slv_we(slv_we),
      .slv_be(slv_be),
      .slv_wdata(slv_wdata),
      .slv_gnt(slv_gnt),
      .slv_rvalid(slv_rvalid),
      .slv_rdata(slv_rdata),
      .bus_err(bus_err)
   );

   // Free-running clock; inputs change and outputs are sampled around the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value with its expected value and logs any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] anyOut();
      return {31'b0, |{peri_gnt, peri_rvalid, peri_rdata, slv_req, slv_addr, slv_we, slv_be, slv_wdata, bus_err}};
   endfunction

   // Reference model: derives the response cycle, data and error purely from the
   // address map, the slave's grant/response delays and the timeout allowance.
   function automatic void modelAccess(input logic [31:0] addr, input logic we, input int g, input int r,
                                       input logic [31:0] sdata, output int lat, output logic [31:0] rd,
                                       output bit err, output int reqCyc);
      int  slot;
      int  gntCycle;
      bit  ok;
      slot = int'((addr >> 12) & 32'hF);
      ok   = 1'b0;
      if (slot >= NS || (addr >> 16) != 0) begin
         lat = 1; reqCyc = 0;
      end else if (g >= T) begin
         lat = T + 1; reqCyc = T;
      end else begin
         gntCycle = 1 + g;
         reqCyc   = gntCycle;
         if (r == 0) begin
            lat = gntCycle + 1; ok = 1'b1;
         end else if (r <= T) begin
            lat = gntCycle + r + 1; ok = 1'b1;
         end else begin
            lat = gntCycle + T + 1;
         end
      end
      err = !ok;
      rd  = (ok && !we) ? sdata : 32'h0;
   endfunction

   // Runs one access from grant to response, playing the selected slave on a fixed
   // schedule and optionally toggling the other slaves' handshakes at random.
   task automatic applyStimulus(input string name, input logic [31:0] addr, input logic we, input logic [3:0] be,
                                input logic [31:0] wdata, input int g, input int r, input logic [31:0] sdata,
                                input bit spur, input int expLat, input logic [31:0] expRd, input bit expErr,
                                input int expReq);
      int          sel;
      logic [NS-1:0] oneHot;
      int          reqCount, fieldErrs, gntErrs, idleErrs, gotLat;
      logic [31:0] gotRd;
      sel    = int'((addr >> 12) & 32'hF);
      oneHot = (sel < NS && (addr >> 16) == 0) ? (NS'(1) << sel) : '0;
      reqCount = 0; fieldErrs = 0; gntErrs = 0; idleErrs = 0; gotLat = -1; gotRd = 32'h0;

      @(negedge clk);
      peri_req   = 1'b1;
      peri_addr  = addr;
      peri_write = we;
      peri_be    = be;
      peri_wdata = wdata;
      slv_gnt    = '1;
      slv_rvalid = '1;
      for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = $urandom;
      #1;
      checkOutput({name, "/gnt"}, {31'b0, peri_gnt}, 32'h1);
      checkOutput({name, "/idleOutputs"}, {29'b0, peri_rvalid, |peri_rdata, |slv_req}, 32'h0);

      for (int k = 1; k <= 3*T + 10; k++) begin
         @(negedge clk);
         peri_req   = spur && (k < expLat);
         slv_gnt    = spur ? (NS'($urandom) & ~oneHot) : '0;
         slv_rvalid = spur ? (NS'($urandom) & ~oneHot) : '0;
         if (k == 1 + g)     slv_gnt    = slv_gnt | oneHot;
         if (k == 1 + g + r) slv_rvalid = slv_rvalid | oneHot;
         for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = $urandom;
         if (oneHot != 0) slv_rdata[32*sel +: 32] = sdata;
         #1;
         if (peri_gnt) gntErrs++;
         if (slv_req != 0) begin
            reqCount++;
            if (slv_req !== oneHot || slv_addr !== (addr & 32'hFFF) || slv_we !== we ||
                slv_be !== be || slv_wdata !== wdata) fieldErrs++;
         end else if (slv_addr != 0 || slv_we || slv_be != 0 || slv_wdata != 0) begin
            fieldErrs++;
         end
         if (peri_rvalid) begin
            gotLat = k;
            gotRd  = peri_rdata;
            break;
         end
         if (peri_rdata != 0) idleErrs++;
      end
      peri_req  = 1'b0;
      expBusErr = expBusErr | expErr;

      checkOutput({name, "/latency"}, 32'(gotLat), 32'(expLat));
      checkOutput({name, "/rdata"}, gotRd, expRd);
      checkOutput({name, "/reqCycles"}, 32'(reqCount), 32'(expReq));
      checkOutput({name, "/slaveFields"}, 32'(fieldErrs), 32'h0);
      checkOutput({name, "/gntWhileBusy"}, 32'(gntErrs), 32'h0);
      checkOutput({name, "/rdataIdle"}, 32'(idleErrs), 32'h0);
      checkOutput({name, "/busErr"}, {31'b0, bus_err}, {31'b0, expBusErr});
   endtask

   int gChoices[6];
   int rChoices[6];

   initial begin
      nChecks = 0; nFails = 0; expBusErr = 1'b0;
      rst_n = 1'b0; peri_req = 1'b0; peri_addr = '0; peri_write = 1'b0; peri_be = '0; peri_wdata = '0;
      slv_gnt = '0; slv_rvalid = '0; slv_rdata = '0;

      vecs[0] = '{"rdSlv1",      32'h0000_1004, 1'b0, 4'hF, 32'h0,         0,     1,     32'hA5A5_0001, 1'b0, 3,  32'hA5A5_0001, 1'b0, 1};
      vecs[1] = '{"wrSlv0",      32'h0000_0010, 1'b1, 4'h3, 32'h1234_5678, 0,     1,     32'hDEAD_BEEF, 1'b0, 3,  32'h0,         1'b0, 1};
      vecs[2] = '{"gntRvSame",   32'h0000_2ABC, 1'b0, 4'hC, 32'h0,         2,     0,     32'h1111_2222, 1'b0, 4,  32'h1111_2222, 1'b0, 3};
      vecs[3] = '{"slv3Late",    32'h0000_3FFC, 1'b0, 4'hF, 32'h0,         0,     5,     32'hCAFE_0003, 1'b1, 7,  32'hCAFE_0003, 1'b0, 1};
      vecs[4] = '{"unmapped",    32'h0000_4000, 1'b0, 4'hF, 32'h0,         0,     1,     32'h5555_5555, 1'b0, 1,  32'h0,         1'b1, 0};
      vecs[5] = '{"upperBits",   32'h1000_1000, 1'b1, 4'hF, 32'hFFFF_0000, 0,     1,     32'h6666_6666, 1'b0, 1,  32'h0,         1'b1, 0};
      vecs[6] = '{"gntTimeout",  32'h0000_2000, 1'b0, 4'hF, 32'h0,         T,     1,     32'h7777_7777, 1'b0, 21, 32'h0,         1'b1, 20};
      vecs[7] = '{"gntLastCyc",  32'h0000_2000, 1'b0, 4'hF, 32'h0,         T-1,   1,     32'h0000_0077, 1'b1, 22, 32'h0000_0077, 1'b0, 20};
      vecs[8] = '{"rvTimeout",   32'h0000_1000, 1'b0, 4'hF, 32'h0,         0,     T+1,   32'h8888_8888, 1'b0, 22, 32'h0,         1'b1, 1};
      vecs[9] = '{"rvLastCyc",   32'h0000_1000, 1'b0, 4'hF, 32'h0,         0,     T,     32'h9999_0001, 1'b0, 22, 32'h9999_0001, 1'b0, 1};

      @(negedge clk);
      #1;
      checkOutput("resetOutputs", anyOut(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].name, vecs[v].addr, vecs[v].we, vecs[v].be, vecs[v].wdata, vecs[v].g, vecs[v].r,
                       vecs[v].sdata, vecs[v].spur, vecs[v].expLat, vecs[v].expRd, vecs[v].expErr, vecs[v].expReq);
      end

      // Reset while waiting for slave 1's response: the pending response must never surface.
      @(negedge clk);
      peri_req = 1'b1; peri_addr = 32'h0000_1008; peri_write = 1'b0; peri_be = 4'hF;
      slv_gnt = '0; slv_rvalid = '0;
      #1;
      checkOutput("rstSeq/gnt", {31'b0, peri_gnt}, 32'h1);
      @(negedge clk);
      peri_req = 1'b0; slv_gnt = 4'b0010;
      @(negedge clk);
      slv_gnt = '0;
      #1;
      checkOutput("rstSeq/inResp", {31'b0, |slv_req | peri_rvalid}, 32'h0);
      rst_n = 1'b0;
      expBusErr = 1'b0;
      #1;
      checkOutput("rstSeq/outputsLow", anyOut(), 32'h0);
      @(negedge clk);
      #1;
      checkOutput("rstSeq/outputsHeld", anyOut(), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      slv_rvalid = 4'b0010;
      slv_rdata[63:32] = 32'hBAD0_BAD0;
      @(negedge clk);
      slv_rvalid = '0;
      #1;
      checkOutput("rstSeq/noStaleResp", {31'b0, peri_rvalid}, 32'h0);
      applyStimulus("afterRst", 32'h0000_1004, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0,
                    3, 32'h0BAD_F00D, 1'b0, 1);

      gChoices = '{0, 1, 2, 3, T-1, T};
      rChoices = '{0, 1, 2, 5, T, T+1};
      for (int n = 0; n < 60; n++) begin
         logic [31:0] addr, wdata, sdata, rd;
         logic        we;
         logic [3:0]  be;
         int          g, r, lat, reqCyc;
         bit          err, spur;
         addr = (32'($urandom_range(0, 5)) << 12) | ($urandom & 32'h0000_0FFF);
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(16, 31));
         we    = 1'($urandom_range(0, 1));
         be    = 4'($urandom);
         wdata = $urandom;
         sdata = $urandom;
         g     = ($urandom_range(0, 3) == 0) ? gChoices[$urandom_range(0, 5)] : int'($urandom_range(0, 3));
         r     = ($urandom_range(0, 3) == 0) ? rChoices[$urandom_range(0, 5)] : int'($urandom_range(0, 4));
         spur  = 1'($urandom_range(0, 1));
         modelAccess(addr, we, g, r, sdata, lat, rd, err, reqCyc);
         applyStimulus($sformatf("rand%0d", n), addr, we, be, wdata, g, r, sdata, spur, lat, rd, err, reqCyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
